// File: rtl/alu_ctrl_exec.sv
// ALU control decode plus execute unit behind valid/ready handshakes.
// Single-cycle ops finish one cycle after accept; MUL is an iterative shift-add over WIDTH cycles.
module alu_ctrl_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               err,
    output logic [3:0]         opcode
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                           OP_SLT = 4'h4, OP_NOR = 4'h5, OP_SLL = 4'h6, OP_SRL = 4'h7,
                           OP_MUL = 4'h8, OP_ERR = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    state_t state, state_nx;

    logic [3:0]       dec_op;
    logic             dec_err, dec_mul, accept, mul_last;
    logic [WIDTH-1:0] alu_res, acc_nx;
    logic [WIDTH-1:0] res_q, ma, mb, acc;
    logic             zero_q, err_q;
    logic [3:0]       opc_q;
    logic [CW-1:0]    cnt;

    always_comb begin
        dec_op  = OP_ADD;
        dec_err = 1'b0;
        case (alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: dec_op = OP_ADD;
                    6'b100010: dec_op = OP_SUB;
                    6'b100100: dec_op = OP_AND;
                    6'b100101: dec_op = OP_OR;
                    6'b101010: dec_op = OP_SLT;
                    6'b100111: dec_op = OP_NOR;
                    6'b000000: dec_op = OP_SLL;
                    6'b000010: dec_op = OP_SRL;
                    6'b011000: dec_op = OP_MUL;
                    default:   dec_err = 1'b1;
                endcase
            end
            default: dec_err = 1'b1;
        endcase
    end

    assign dec_mul = !dec_err && (dec_op == OP_MUL);

    always_comb begin
        alu_res = '0;
        if (!dec_err) begin
            case (dec_op)
                OP_ADD:  alu_res = op_a + op_b;
                OP_SUB:  alu_res = op_a - op_b;
                OP_AND:  alu_res = op_a & op_b;
                OP_OR:   alu_res = op_a | op_b;
                OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                OP_NOR:  alu_res = ~(op_a | op_b);
                OP_SLL:  alu_res = op_b << shamt;
                OP_SRL:  alu_res = op_b >> shamt;
                default: alu_res = '0;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid & in_ready;
    assign acc_nx    = acc + (mb[0] ? ma : '0);
    // Last of WIDTH iterations writes the product straight into the result register.
    assign mul_last  = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = dec_mul ? S_MUL : S_DONE;
            S_MUL:   if (mul_last) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            zero_q <= 1'b0;
            err_q  <= 1'b0;
            opc_q  <= 4'h0;
            ma     <= '0;
            mb     <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    if (dec_mul) begin
                        ma    <= op_a;
                        mb    <= op_b;
                        acc   <= '0;
                        cnt   <= '0;
                        err_q <= 1'b0;
                        opc_q <= OP_MUL;
                    end else begin
                        res_q  <= alu_res;
                        zero_q <= (alu_res == '0);
                        err_q  <= dec_err;
                        opc_q  <= dec_err ? OP_ERR : dec_op;
                    end
                end
                S_MUL: begin
                    acc <= acc_nx;
                    ma  <= ma << 1;
                    mb  <= mb >> 1;
                    cnt <= cnt + CW'(1);
                    if (mul_last) begin
                        res_q  <= acc_nx;
                        zero_q <= (acc_nx == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = res_q;
    assign zero   = zero_q;
    assign err    = err_q;
    assign opcode = opc_q;
endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed and random checks of alu_ctrl_exec against an arithmetic reference model.
module tb_alu_ctrl_exec;
    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, zero, err;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] op_a, op_b, result;
    logic [3:0]  opcode;
    int          errs, checks;

    alu_ctrl_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .shamt(shamt), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .err(err), .opcode(opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input logic [1:0] aop, input logic [5:0] f, input logic [4:0] sh,
                             input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] r, output logic [3:0] opc, output logic e);
        logic [63:0] p;
        e = 1'b0; r = '0; opc = 4'h0;
        p = {32'b0, a} * {32'b0, b};
        if (aop == 2'b00)      begin r = a + b; opc = 4'h0; end
        else if (aop == 2'b01) begin r = a - b; opc = 4'h1; end
        else if (aop == 2'b11) e = 1'b1;
        else begin
            case (f)
                6'h20: begin r = a + b; opc = 4'h0; end
                6'h22: begin r = a - b; opc = 4'h1; end
                6'h24: begin r = a & b; opc = 4'h2; end
                6'h25: begin r = a | b; opc = 4'h3; end
                6'h2a: begin r = (int'(a) < int'(b)) ? 32'd1 : 32'd0; opc = 4'h4; end
                6'h27: begin r = ~(a | b); opc = 4'h5; end
                6'h00: begin r = b << sh; opc = 4'h6; end
                6'h02: begin r = b >> sh; opc = 4'h7; end
                6'h18: begin r = p[31:0]; opc = 4'h8; end
                default: e = 1'b1;
            endcase
        end
        if (e) begin r = '0; opc = 4'hF; end
    endtask

    task automatic run_op(input logic [1:0] aop, input logic [5:0] f, input logic [4:0] sh,
                          input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er, held;
        logic [3:0]  eo;
        logic        ee;
        int          n, lat, explat;
        ref_model(aop, f, sh, a, b, er, eo, ee);
        explat = (eo == 4'h8) ? 33 : 1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("in_ready_before", {31'b0, in_ready}, 32'd1);
        alu_op = aop; funct = f; shamt = sh; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom; alu_op = $urandom; funct = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin
            check("in_ready_busy", {31'b0, in_ready}, 32'd0);
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, explat);
        check("result", result, er);
        check("zero", {31'b0, zero}, {31'b0, (er == 32'd0)});
        check("err", {31'b0, err}, {31'b0, ee});
        check("opcode", {28'b0, opcode}, {28'b0, eo});
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_result", result, held);
            check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", {31'b0, out_valid}, 32'd0);
        check("drain_in_ready", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [5:0] ftab [10];
        int seen;
        ftab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h00, 6'h02, 6'h18, 6'h3f};
        errs = 0; checks = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; funct = '0; shamt = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_opcode", {28'b0, opcode}, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        run_op(2'b00, 6'h00, 5'd0, 32'd5, 32'd7, 0);
        run_op(2'b01, 6'h00, 5'd0, 32'd9, 32'd9, 0);
        run_op(2'b10, 6'h2a, 5'd0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(2'b10, 6'h02, 5'd31, 32'd0, 32'h8000_0000, 0);
        run_op(2'b10, 6'h27, 5'd0, 32'd0, 32'd0, 0);
        run_op(2'b10, 6'h00, 5'd4, 32'd0, 32'h0000_00F1, 0);
        run_op(2'b10, 6'h18, 5'd0, 32'h0001_0001, 32'h0001_0001, 0);
        run_op(2'b10, 6'h18, 5'd0, 32'h1234_5678, 32'd0, 1);
        run_op(2'b10, 6'h24, 5'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5);
        run_op(2'b10, 6'h3f, 5'd0, 32'd3, 32'd4, 0);
        run_op(2'b11, 6'h20, 5'd0, 32'd3, 32'd4, 0);

        // reset pulse in the middle of a multiply must discard it
        alu_op = 2'b10; funct = 6'h18; op_a = 32'd7; op_b = 32'd6; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_opcode", {28'b0, opcode}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
        check("midrst_no_valid", seen, 0);
        run_op(2'b00, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd2, 0);

        for (int k = 0; k < 16; k++) begin
            logic [1:0] aop;
            aop = (k % 5 == 4) ? 2'($urandom_range(0, 3)) : 2'b10;
            run_op(aop, ftab[$urandom_range(0, 9)], 5'($urandom), $urandom, $urandom,
                   $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
